// File: rtl/m2b_kron_d2.sv
// Second-order multiplicative-to-Boolean mask conversion: peels m2, m1, a off in
// three registered stages, refreshing shares with fresh randomness after every product.
module m2b_kron_d2 #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] mul_inp,
  input  logic [2:0]  delta_inp,
  input  logic [47:0] rnd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] bool_out,
  output logic        err_mask
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [14:0] p;
    p = 15'h0000;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (y[i] ? (15'(x) << i) : 15'h0000);
    end
    for (int i = 14; i >= 8; i--) begin
      p = p ^ (p[i] ? (15'({1'b1, POLY}) << (i - 8)) : 15'h0000);
    end
    return p[7:0];
  endfunction

  logic [7:0] w_a_in, w_m1_in, w_m2_in;
  logic [7:0] w_r0, w_r1, w_r2, w_r3, w_r4, w_r5;
  logic       w_stall, w_accept;
  logic [7:0] w_p2_0, w_p2_1, w_p2_2;
  logic [7:0] w_p3_0, w_p3_1, w_p3_2;

  logic       r_v1, r_v2, r_v3;
  logic [7:0] r_b0, r_b1, r_b2, r_a1, r_m1;
  logic [2:0] r_d1;
  logic [7:0] r_c0, r_c1, r_c2, r_a2;
  logic [2:0] r_d2;
  logic [7:0] r_s0, r_s1, r_s2;
  logic       r_err;

  assign w_a_in  = mul_inp[23:16];
  assign w_m1_in = mul_inp[15:8];
  assign w_m2_in = mul_inp[7:0];
  assign w_r0    = rnd[7:0];
  assign w_r1    = rnd[15:8];
  assign w_r2    = rnd[23:16];
  assign w_r3    = rnd[31:24];
  assign w_r4    = rnd[39:32];
  assign w_r5    = rnd[47:40];

  assign w_stall  = r_v3 & ~out_ready;
  assign w_accept = in_valid & ~w_stall;

  // Each product is formed from a single share index; shares only meet after fresh masks.
  assign w_p2_0 = gf_mul(r_b0, r_m1);
  assign w_p2_1 = gf_mul(r_b1, r_m1);
  assign w_p2_2 = gf_mul(r_b2, r_m1);
  assign w_p3_0 = gf_mul(r_c0, r_a2);
  assign w_p3_1 = gf_mul(r_c1, r_a2);
  assign w_p3_2 = gf_mul(r_c2, r_a2);

  // Stage 1: split m2 into three Boolean shares, capture a, m1 and delta.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_b0 <= 8'h00;
      r_b1 <= 8'h00;
      r_b2 <= 8'h00;
      r_a1 <= 8'h00;
      r_m1 <= 8'h00;
      r_d1 <= 3'b000;
    end else if (!w_stall) begin
      r_v1 <= w_accept;
      r_b0 <= w_m2_in ^ w_r0 ^ w_r1;
      r_b1 <= w_r0;
      r_b2 <= w_r1;
      r_a1 <= w_a_in;
      r_m1 <= w_m1_in;
      r_d1 <= delta_inp;
    end
  end

  // Stage 2: multiply each share by m1 and remask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2 <= 1'b0;
      r_c0 <= 8'h00;
      r_c1 <= 8'h00;
      r_c2 <= 8'h00;
      r_a2 <= 8'h00;
      r_d2 <= 3'b000;
    end else if (!w_stall) begin
      r_v2 <= r_v1;
      r_c0 <= w_p2_0 ^ w_r2 ^ w_r3;
      r_c1 <= w_p2_1 ^ w_r2;
      r_c2 <= w_p2_2 ^ w_r3;
      r_a2 <= r_a1;
      r_d2 <= r_d1;
    end
  end

  // Stage 3: multiply by a, remask, and fold in the Kronecker delta shares bitwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3 <= 1'b0;
      r_s0 <= 8'h00;
      r_s1 <= 8'h00;
      r_s2 <= 8'h00;
    end else if (!w_stall) begin
      r_v3 <= r_v2;
      r_s0 <= w_p3_0 ^ w_r4 ^ w_r5 ^ {7'b0000000, r_d2[0]};
      r_s1 <= w_p3_1 ^ w_r4 ^ {7'b0000000, r_d2[1]};
      r_s2 <= w_p3_2 ^ w_r5 ^ {7'b0000000, r_d2[2]};
    end
  end

  // Sticky flag: a zero mask makes the multiplicative sharing meaningless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept && ((w_m1_in == 8'h00) || (w_m2_in == 8'h00))) begin
      r_err <= 1'b1;
    end
  end

  assign in_ready  = ~w_stall;
  assign out_valid = r_v3;
  assign bool_out  = {r_s2, r_s1, r_s0};
  assign err_mask  = r_err;

endmodule
